// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART_TX byte transmitter among NREQ byte-stream requesters.
//   A requester is picked round-robin, but the current owner may keep the
//   grant for up to BURST_LEN consecutive bytes while others wait. Each byte is
//   handed to UART_TX with a one-cycle tx_start pulse. The arbiter then waits
//   for tx_busy to rise and fall before it accepts the next byte. If tx_busy
//   does not rise within BUSY_TMO cycles, the byte is dropped and the sticky
//   tx_err flag is set.
//
//   Optional feature macro: UART_TX_ARB_TAG_EN
//     When defined, a tag byte 8'hA0|id is sent ahead of a data byte whenever
//     the source id differs from the id of the last tag actually sent. This
//     also applies to the first byte after reset.
//
// Ports
//   clk_i        clock
//   reset_n_i    synchronous reset, active low
//   req_valid_i  [NREQ]    requester i offers req_data_i[8*i+:8]
//   req_data_i   [8*NREQ]  packed request bytes
//   req_ready_o  [NREQ]    one-hot accept strobe (combinational)
//   sdata_o      [8]       byte to UART_TX, stable from START until IDLE
//   tx_start_o             one-cycle start pulse to UART_TX
//   tx_busy_i              UART_TX busy
//   grant_id_o   [3]       id of the last accepted requester
//   busy_o                 high whenever the FSM is not in IDLE
//   tx_err_o               sticky: tx_busy failed to rise in time
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4,
  parameter int BUSY_TMO  = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [7:0]        sdata_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  output logic [2:0]        grant_id_o,
  output logic              busy_o,
  output logic              tx_err_o
);

  localparam int PTRW = $clog2(NREQ);
  localparam int BW   = $clog2(BURST_LEN + 1);
  localparam int CNTW = $clog2(BUSY_TMO);
  localparam logic [BW-1:0]   BURST_MAX = BW'(BURST_LEN);
  localparam logic [CNTW-1:0] TMO_LAST  = CNTW'(BUSY_TMO - 1);

`ifdef UART_TX_ARB_TAG_EN
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_START       = 3'd1,
    S_WAIT_HI     = 3'd2,
    S_WAIT_LO     = 3'd3,
    S_TAG_START   = 3'd4,
    S_TAG_WAIT_HI = 3'd5,
    S_TAG_WAIT_LO = 3'd6
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [7:0]      sdata_q, sdata_d;
  logic            tx_start_q, tx_start_d;
  logic [2:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            owner_vld_q, owner_vld_d;
  logic [CNTW-1:0] tmo_q, tmo_d;
`ifdef UART_TX_ARB_TAG_EN
  logic [7:0]      data_q, data_d;
  logic [2:0]      last_id_q, last_id_d;
  logic            last_vld_q, last_vld_d;
`endif

  logic            win_vld_s;
  logic [PTRW-1:0] win_id_s;
  logic [PTRW-1:0] idx_s;
  logic            keep_s;
  logic            accept_s;
  logic [7:0]      win_byte_s;

  // Winner selection and the combinational accept strobe
  always_comb begin
    win_vld_s = 1'b0;
    win_id_s  = '0;
    idx_s     = '0;
    // ptr_q is the current owner; it may keep the grant until its burst is used up
    keep_s    = owner_vld_q && req_valid_i[ptr_q] && (burst_q < BURST_MAX);
    // Scan from the farthest candidate to the nearest, so the first valid
    // requester after ptr_q wins. The owner itself is the last choice.
    for (int k = NREQ; k >= 1; k--) begin
      idx_s     = PTRW'((int'(ptr_q) + k) % NREQ);
      win_id_s  = req_valid_i[idx_s] ? idx_s : win_id_s;
      win_vld_s = win_vld_s | req_valid_i[idx_s];
    end
    win_id_s    = keep_s ? ptr_q : win_id_s;
    win_byte_s  = 8'(req_data_i >> {win_id_s, 3'b000});
    // No accept while UART_TX is busy, even if this arbiter did not start it
    accept_s    = reset_n_i && (state_q == S_IDLE) && !tx_busy_i && win_vld_s;
    req_ready_o = accept_s ? (NREQ'(1) << win_id_s) : '0;
  end

  // Round-robin pointer, owner and burst bookkeeping
  always_comb begin
    ptr_d       = ptr_q;
    burst_d     = burst_q;
    owner_vld_d = owner_vld_q;
    if (accept_s) begin
      owner_vld_d = 1'b1;
      if (owner_vld_q && (win_id_s == ptr_q)) begin
        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
      end else begin
        ptr_d   = win_id_s;
        burst_d = BW'(1);
      end
    end else if ((state_q == S_IDLE) && owner_vld_q && !req_valid_i[ptr_q]) begin
      // Owner went quiet between bytes: its burst ends here
      burst_d     = '0;
      owner_vld_d = 1'b0;
    end else begin
      burst_d = burst_q;
    end
  end

  // Byte sequencing FSM: next state and registered-output next values
  always_comb begin
    state_d    = state_q;
    sdata_d    = sdata_q;
    grant_d    = grant_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    tx_start_d = 1'b0;
`ifdef UART_TX_ARB_TAG_EN
    data_d     = data_q;
    last_id_d  = last_id_q;
    last_vld_d = last_vld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          grant_d    = 3'(win_id_s);
          tx_start_d = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
          data_d = win_byte_s;
          if (!last_vld_q || (last_id_q != 3'(win_id_s))) begin
            sdata_d = {5'b10100, 3'(win_id_s)};
            state_d = S_TAG_START;
          end else begin
            sdata_d = win_byte_s;
            state_d = S_START;
          end
`else
          sdata_d = win_byte_s;
          state_d = S_START;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT_HI;
        tmo_d   = '0;
      end
      S_WAIT_HI: begin
        if (tx_busy_i) begin
          state_d = S_WAIT_LO;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + CNTW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      S_TAG_START: begin
        state_d = S_TAG_WAIT_HI;
        tmo_d   = '0;
      end
      S_TAG_WAIT_HI: begin
        if (tx_busy_i) begin
          state_d = S_TAG_WAIT_LO;
        end else if (tmo_q == TMO_LAST) begin
          // Tag lost: the data byte behind it is dropped too
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + CNTW'(1);
        end
      end
      S_TAG_WAIT_LO: begin
        if (!tx_busy_i) begin
          sdata_d    = data_q;
          tx_start_d = 1'b1;
          last_id_d  = grant_q;
          last_vld_d = 1'b1;
          state_d    = S_START;
        end else begin
          state_d = S_TAG_WAIT_LO;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      sdata_q     <= 8'h00;
      tx_start_q  <= 1'b0;
      grant_q     <= 3'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ptr_q       <= '0;
      burst_q     <= '0;
      owner_vld_q <= 1'b0;
      tmo_q       <= '0;
`ifdef UART_TX_ARB_TAG_EN
      data_q      <= 8'h00;
      last_id_q   <= 3'd0;
      last_vld_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sdata_q     <= sdata_d;
      tx_start_q  <= tx_start_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      burst_q     <= burst_d;
      owner_vld_q <= owner_vld_d;
      tmo_q       <= tmo_d;
`ifdef UART_TX_ARB_TAG_EN
      data_q      <= data_d;
      last_id_q   <= last_id_d;
      last_vld_q  <= last_vld_d;
`endif
    end
  end

  assign sdata_o    = sdata_q;
  assign tx_start_o = tx_start_q;
  assign grant_id_o = grant_q;
  assign busy_o     = busy_q;
  assign tx_err_o   = err_q;

endmodule
